ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 The block SHALL have parameter RAM_LAT, default 1, RAM access cycles (1..4).
REQ-004 The block SHALL have these ports, one clock, reset asynchronous and active-low:
  clk  in  1  rising-edge clock
  res  in  1  asynchronous active-low reset
  cpu_req  in  1  CPU access request, held until cpu_ack
  cpu_we  in  1  1 = store, 0 = load
  cpu_addr  in  ADDR_W  CPU address
  cpu_wdata  in  DATA_W  CPU store data
  cpu_ack  out  1  one-cycle completion pulse
  cpu_rdata  out  DATA_W  CPU load data, valid while cpu_ack
  cpu_stall  out  1  drives CPU enable low while CPU access pending
  dma_req  in  1  loader/DMA request, held until dma_ack
  dma_we, dma_addr, dma_wdata  in  1/ADDR_W/DATA_W  as cpu_*
  dma_ack  out  1  one-cycle completion pulse
  dma_rdata  out  DATA_W  DMA load data, valid while dma_ack
  ram_sel  out  1  RAM chip select
  ram_we  out  1  RAM write strobe
  ram_addr  out  ADDR_W  RAM address
  ram_wdata  out  DATA_W  RAM write data
  ram_rdata  in  DATA_W  RAM read data

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-006 IDLE: any req high at a clock edge -> pick winner, latch its we/addr/wdata, record grant, load access counter with RAM_LAT-1, go ACCESS.
REQ-007 Arbitration SHALL be two-way round-robin: on a tie the port not granted last wins; a lone requester always wins.
REQ-008 ACCESS: ram_sel=1, ram_we=latched we, ram_addr/ram_wdata=latched values, constant for exactly RAM_LAT cycles; in IDLE/DONE ram_sel=ram_we=0.
REQ-009 On the last ACCESS cycle the block SHALL register ram_rdata into the granted port's rdata register if the access is a load, then go DONE.
REQ-010 DONE: the granted port's ack=1 for exactly one cycle; the other ack stays 0; next state IDLE.
REQ-011 Latency SHALL be fixed: a req sampled at edge t gives ack high in the cycle after edge t+RAM_LAT+1; load data is valid in that same cycle.
REQ-012 Requests SHALL be non-abortable: a req dropped during ACCESS or DONE still completes, and the ack is still issued.
REQ-013 Req SHALL be ignored in ACCESS and DONE; a req still high in IDLE after its ack counts as a new request.
REQ-014 cpu_rdata/dma_rdata SHALL hold their last value until overwritten by a later load for the same port; stores SHALL not modify them.
REQ-015 cpu_stall SHALL be the combinational value cpu_req AND NOT cpu_ack.
REQ-016 Addresses SHALL pass unmodified, with no wrap or arithmetic; the access counter SHALL count down and never wrap.

Reset
REQ-017 res low SHALL, asynchronously: state=IDLE, counter=0, all latched request fields=0, cpu_rdata=dma_rdata=0, both acks=0, ram_sel=ram_we=0, ram_addr=ram_wdata=0, last-grant=DMA (CPU wins the first tie).
REQ-018 Reset during ACCESS SHALL drop ram_sel at once; no ack is issued for the aborted access.
REQ-019 After res rises, the first request SHALL be sampled at the first rising clk edge.

Structure
REQ-020 Package ram_arbiter_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), port index constants PORT_CPU=0/PORT_DMA=1, and default ADDR_W/DATA_W/RAM_LAT.
REQ-021 The round-robin pick SHALL be a sub-module rr_arbiter2, combinational (req[1:0], last) -> grant index; the FSM, counter and registers SHALL stay in ram_arbiter.

Verification
REQ-022 RAM_LAT=1, CPU load addr 0x123, RAM returns 0xBEEF -> ram_sel high 1 cycle with addr 0x123, cpu_ack 2 cycles after req sample, cpu_rdata=0xBEEF, cpu_stall low from the ack cycle.
REQ-023 Both req high from reset (CPU store 0x010<-0x1111, DMA store 0x020<-0x2222), held -> CPU granted first, DMA second, then alternating CPU, DMA, ...; never two consecutive grants to one port.
REQ-024 RAM_LAT=3, DMA load 0xFFF -> ram_sel high exactly 3 cycles, addr stable, dma_ack in cycle 5 after sample; a CPU req arriving mid-access waits and is served next.
REQ-025 CPU req dropped in the ACCESS cycle -> access completes, cpu_ack pulses once, no second access.
REQ-026 res asserted mid-ACCESS (RAM_LAT=3, 2nd cycle) -> ram_sel low immediately, no ack, all outputs 0; after release, a CPU req is served normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the CPU/DMA RAM arbiter.
// Imported by the arbiter top and its round-robin picker.
package ram_arbiter_pkg;

    localparam int ADDR_W_DFLT  = 12;
    localparam int DATA_W_DFLT  = 16;
    localparam int RAM_LAT_DFLT = 1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between CPU and DMA requesters.
// Pure combinational; the last-grant state lives in the caller.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // On a tie favour the port that did not win last time
    always_comb begin
        grant = PORT_CPU;
        if (req[PORT_CPU] && req[PORT_DMA]) begin
            grant = ~last;
        end else if (req[PORT_DMA]) begin
            grant = PORT_DMA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between a CPU and a DMA/loader port.
// Fixed-latency, non-abortable accesses with round-robin arbitration.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int RAM_LAT = RAM_LAT_DFLT
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_sel,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt_q, gnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              ram_sel_q, ram_sel_d;
    logic              ram_we_q, ram_we_d;
    logic              pick;

    rr_arbiter2 u_rr (
        .req   ({dma_req, cpu_req}),
        .last  (gnt_q),
        .grant (pick)
    );

    // Next-state logic; acks are registered out of DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt_d       = gnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        ram_sel_d   = ram_sel_q;
        ram_we_d    = ram_we_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    gnt_d     = pick;
                    we_d      = (pick == PORT_DMA) ? dma_we : cpu_we;
                    addr_d    = (pick == PORT_DMA) ? dma_addr : cpu_addr;
                    wdata_d   = (pick == PORT_DMA) ? dma_wdata : cpu_wdata;
                    cnt_d     = CNT_LOAD;
                    ram_sel_d = 1'b1;
                    ram_we_d  = (pick == PORT_DMA) ? dma_we : cpu_we;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (gnt_q == PORT_DMA) begin
                            dma_rdata_d = ram_rdata;
                        end else begin
                            cpu_rdata_d = ram_rdata;
                        end
                    end
                    ram_sel_d = 1'b0;
                    ram_we_d  = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                cpu_ack_d = (gnt_q == PORT_CPU);
                dma_ack_d = (gnt_q == PORT_DMA);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= PORT_DMA;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            ram_sel_q   <= 1'b0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            ram_sel_q   <= ram_sel_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign ram_sel   = ram_sel_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at RAM_LAT=1,
// one at RAM_LAT=3, sharing clock and reset.
module tb_ram_arbiter;

    logic clk;
    logic res;

    logic        c1_req, c1_we, c1_ack, c1_stall;
    logic [11:0] c1_addr;
    logic [15:0] c1_wdata, c1_rdata;
    logic        d1_req, d1_we, d1_ack;
    logic [11:0] d1_addr;
    logic [15:0] d1_wdata, d1_rdata;
    logic        r1_sel, r1_we;
    logic [11:0] r1_addr;
    logic [15:0] r1_wdata, r1_rdata;

    logic        c3_req, c3_we, c3_ack, c3_stall;
    logic [11:0] c3_addr;
    logic [15:0] c3_wdata, c3_rdata;
    logic        d3_req, d3_we, d3_ack;
    logic [11:0] d3_addr;
    logic [15:0] d3_wdata, d3_rdata;
    logic        r3_sel, r3_we;
    logic [11:0] r3_addr;
    logic [15:0] r3_wdata, r3_rdata;

    int n_chk;
    int n_fail;

    // Simple RAM read models
    assign r1_rdata = (r1_addr == 12'h123) ? 16'hBEEF : {4'h0, r1_addr};
    assign r3_rdata = ~{4'h0, r3_addr};

    ram_arbiter #(.ADDR_W(12), .DATA_W(16), .RAM_LAT(1)) dut1 (
        .clk(clk), .res(res),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr),
        .cpu_wdata(c1_wdata), .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
        .cpu_stall(c1_stall),
        .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr),
        .dma_wdata(d1_wdata), .dma_ack(d1_ack), .dma_rdata(d1_rdata),
        .ram_sel(r1_sel), .ram_we(r1_we), .ram_addr(r1_addr),
        .ram_wdata(r1_wdata), .ram_rdata(r1_rdata)
    );

    ram_arbiter #(.ADDR_W(12), .DATA_W(16), .RAM_LAT(3)) dut3 (
        .clk(clk), .res(res),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr),
        .cpu_wdata(c3_wdata), .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
        .cpu_stall(c3_stall),
        .dma_req(d3_req), .dma_we(d3_we), .dma_addr(d3_addr),
        .dma_wdata(d3_wdata), .dma_ack(d3_ack), .dma_rdata(d3_rdata),
        .ram_sel(r3_sel), .ram_we(r3_we), .ram_addr(r3_addr),
        .ram_wdata(r3_wdata), .ram_rdata(r3_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        res    = 1'b0;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr = 12'h010; c1_wdata = 16'h1111;
        d1_req = 1'b1; d1_we = 1'b1; d1_addr = 12'h020; d1_wdata = 16'h2222;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = 12'h000; c3_wdata = 16'h0000;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = 12'h000; d3_wdata = 16'h0000;

        // Reset state
        tick();
        tick();
        check("rst_sel1", r1_sel, 0);
        check("rst_we1", r1_we, 0);
        check("rst_addr1", r1_addr, 0);
        check("rst_wdata1", r1_wdata, 0);
        check("rst_cack1", c1_ack, 0);
        check("rst_dack1", d1_ack, 0);
        check("rst_crd1", c1_rdata, 0);
        check("rst_drd1", d1_rdata, 0);
        check("rst_stall1", c1_stall, 1);
        check("rst_sel3", r3_sel, 0);

        // Both stores held from reset: CPU first, then alternate
        res = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            check("rr_sel", r1_sel, (k % 3) == 0);
            check("rr_cack", c1_ack, (k % 6) == 2);
            check("rr_dack", d1_ack, (k % 6) == 5);
            if ((k % 3) == 0) begin
                check("rr_addr", r1_addr, ((k % 6) == 0) ? 12'h010 : 12'h020);
                check("rr_wdata", r1_wdata,
                      ((k % 6) == 0) ? 16'h1111 : 16'h2222);
                check("rr_we", r1_we, 1);
            end
            if (k == 11) begin
                c1_req = 1'b0;
                d1_req = 1'b0;
            end
            tick();
        end
        check("rr_idle", r1_sel, 0);
        check("rr_crd", c1_rdata, 0);
        check("rr_drd", d1_rdata, 0);

        // CPU load at 0x123, RAM_LAT=1
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 12'h123; c1_wdata = 16'h0;
        tick();
        check("ld_sel", r1_sel, 1);
        check("ld_addr", r1_addr, 12'h123);
        check("ld_we", r1_we, 0);
        check("ld_stall", c1_stall, 1);
        check("ld_ack0", c1_ack, 0);
        tick();
        check("ld_sel_done", r1_sel, 0);
        check("ld_ack_done", c1_ack, 0);
        tick();
        check("ld_ack", c1_ack, 1);
        check("ld_dack", d1_ack, 0);
        check("ld_rdata", c1_rdata, 16'hBEEF);
        check("ld_stall_ack", c1_stall, 0);
        c1_req = 1'b0;
        tick();
        check("ld_ack_end", c1_ack, 0);
        check("ld_sel_end", r1_sel, 0);

        // CPU req dropped during ACCESS still completes once
        c1_req = 1'b1; c1_addr = 12'h200;
        tick();
        check("drop_sel", r1_sel, 1);
        check("drop_addr", r1_addr, 12'h200);
        c1_req = 1'b0;
        tick();
        check("drop_done_ack", c1_ack, 0);
        tick();
        check("drop_ack", c1_ack, 1);
        check("drop_rdata", c1_rdata, 16'h0200);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drop_no_ack", c1_ack, 0);
            check("drop_no_sel", r1_sel, 0);
        end

        // DMA load 0xFFF at RAM_LAT=3, CPU arrives mid-access
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 12'hFFF;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("l3_sel", r3_sel, 1);
            check("l3_addr", r3_addr, 12'hFFF);
            check("l3_dack", d3_ack, 0);
            if (j == 1) begin
                c3_req = 1'b1; c3_we = 1'b0; c3_addr = 12'h055;
            end
        end
        check("l3_cstall", c3_stall, 1);
        tick();
        check("l3_sel_done", r3_sel, 0);
        check("l3_dack_done", d3_ack, 0);
        tick();
        check("l3_dack", d3_ack, 1);
        check("l3_cack", c3_ack, 0);
        check("l3_drdata", d3_rdata, 16'hF000);
        d3_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("l3c_sel", r3_sel, 1);
            check("l3c_addr", r3_addr, 12'h055);
            check("l3c_dack", d3_ack, 0);
        end
        tick();
        check("l3c_sel_done", r3_sel, 0);
        tick();
        check("l3c_cack", c3_ack, 1);
        check("l3c_crdata", c3_rdata, 16'hFFAA);
        check("l3c_drdata", d3_rdata, 16'hF000);
        c3_req = 1'b0;
        tick();
        check("l3c_cack_end", c3_ack, 0);

        // Reset in the second ACCESS cycle aborts the access
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 12'h0AB;
        tick();
        check("ra_sel1", r3_sel, 1);
        tick();
        check("ra_sel2", r3_sel, 1);
        res = 1'b0;
        #1;
        check("ra_sel_rst", r3_sel, 0);
        check("ra_we_rst", r3_we, 0);
        check("ra_addr_rst", r3_addr, 0);
        check("ra_crd_rst", c3_rdata, 0);
        check("ra_drd_rst", d3_rdata, 0);
        check("ra_cack_rst", c3_ack, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ra_no_ack", c3_ack, 0);
            check("ra_no_sel", r3_sel, 0);
        end
        res = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("ra2_sel", r3_sel, 1);
            check("ra2_addr", r3_addr, 12'h0AB);
        end
        tick();
        check("ra2_sel_done", r3_sel, 0);
        check("ra2_ack_done", c3_ack, 0);
        tick();
        check("ra2_ack", c3_ack, 1);
        check("ra2_rdata", c3_rdata, 16'hFF54);
        c3_req = 1'b0;
        tick();
        check("ra2_ack_end", c3_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
